// File: rtl/dmem_ctl_pkg.sv
// Shared types and helpers for the data-memory controller: FSM state encoding,
// lane-offset width helper and the registered bus request record.
package dmem_ctl_pkg;

  // Default datapath geometry; the bus request record is sized from these.
  localparam int DMEM_DATA_WIDTH = 64;
  localparam int DMEM_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  // Number of address bits that select a byte lane inside one bus word.
  function automatic int offset_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // One bus request as presented in REQ: word-aligned address, lane-shifted payload.
  typedef struct packed {
    logic                           we;
    logic [DMEM_ADDR_WIDTH-1:0]     addr;
    logic [DMEM_DATA_WIDTH-1:0]     data;
    logic [DMEM_DATA_WIDTH/8-1:0]   mask;
  } dmem_bus_req_t;

endpackage

// File: rtl/dmem_ctl_if.sv
// LSU-side request/response signals and memory-bus handshake of dmem_ctl.
// master = the controller, slave = the LSU plus memory environment around it.
interface dmem_ctl_if
  import dmem_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // LSU request side
  logic                  i_lsu_valid;
  logic                  i_lsu_ram_rd_en;
  logic [ADDR_WIDTH-1:0] i_lsu_ram_rd_addr;
  logic                  i_lsu_ram_wr_en;
  logic [ADDR_WIDTH-1:0] i_lsu_ram_wr_addr;
  logic [DATA_WIDTH-1:0] i_lsu_ram_wr_data;
  logic [MASK_WIDTH-1:0] i_lsu_ram_wr_mask;

  // LSU completion side
  logic [DATA_WIDTH-1:0] o_dmem_ram_rd_data;
  logic                  o_dmem_busy;
  logic                  o_dmem_done;
  logic                  o_dmem_misalign;
  logic                  o_dmem_fault;

  // Memory bus
  logic                  o_bus_req_valid;
  logic                  i_bus_req_ready;
  logic                  o_bus_req_we;
  logic [ADDR_WIDTH-1:0] o_bus_req_addr;
  logic [DATA_WIDTH-1:0] o_bus_req_data;
  logic [MASK_WIDTH-1:0] o_bus_req_mask;
  logic                  i_bus_rsp_valid;
  logic [DATA_WIDTH-1:0] i_bus_rsp_data;
  logic                  o_bus_rsp_ready;

  modport master (
    input  i_lsu_valid, i_lsu_ram_rd_en, i_lsu_ram_rd_addr,
    input  i_lsu_ram_wr_en, i_lsu_ram_wr_addr, i_lsu_ram_wr_data, i_lsu_ram_wr_mask,
    output o_dmem_ram_rd_data, o_dmem_busy, o_dmem_done, o_dmem_misalign, o_dmem_fault,
    output o_bus_req_valid, o_bus_req_we, o_bus_req_addr, o_bus_req_data, o_bus_req_mask,
    input  i_bus_req_ready, i_bus_rsp_valid, i_bus_rsp_data,
    output o_bus_rsp_ready
  );

  modport slave (
    output i_lsu_valid, i_lsu_ram_rd_en, i_lsu_ram_rd_addr,
    output i_lsu_ram_wr_en, i_lsu_ram_wr_addr, i_lsu_ram_wr_data, i_lsu_ram_wr_mask,
    input  o_dmem_ram_rd_data, o_dmem_busy, o_dmem_done, o_dmem_misalign, o_dmem_fault,
    input  o_bus_req_valid, o_bus_req_we, o_bus_req_addr, o_bus_req_data, o_bus_req_mask,
    output i_bus_req_ready, i_bus_rsp_valid, i_bus_rsp_data,
    input  o_bus_rsp_ready
  );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane alignment: shifts store data/mask up to the addressed lane and flags
// masks that spill past the word, and right-aligns a returned load word.
module dmem_align
  import dmem_ctl_pkg::*;
#(
  parameter  int DATA_WIDTH = DMEM_DATA_WIDTH,
  localparam int MASK_W     = DATA_WIDTH / 8,
  localparam int OFF_W      = offset_width(DATA_WIDTH)
) (
  input  logic [OFF_W-1:0]      st_off,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [MASK_W-1:0]     st_mask,
  output logic [DATA_WIDTH-1:0] st_data_sh,
  output logic [MASK_W-1:0]     st_mask_sh,
  output logic                  st_misalign,
  input  logic [OFF_W-1:0]      ld_off,
  input  logic [DATA_WIDTH-1:0] ld_word,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [2*MASK_W-1:0] mask_wide;

  // Mask is shifted in a double-width field so lanes pushed past the word stay visible.
  always_comb begin
    mask_wide   = {{MASK_W{1'b0}}, st_mask} << st_off;
    st_mask_sh  = mask_wide[MASK_W-1:0];
    st_misalign = |mask_wide[2*MASK_W-1:MASK_W];
    st_data_sh  = st_data << {st_off, 3'b000};
    ld_data     = ld_word >> {ld_off, 3'b000};
  end

endmodule

// File: rtl/dmem_ctl.sv
// Data-memory controller: takes one LSU load/store, runs it on a ready/valid bus
// with variable latency, and reports completion with a one-cycle done pulse.
module dmem_ctl
  import dmem_ctl_pkg::*;
#(
  parameter int DATA_WIDTH     = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DMEM_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic        i_clk,
  input logic        i_rst,
  dmem_ctl_if.master bus
);

  localparam int OFF_W = offset_width(DATA_WIDTH);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value of the last WAIT cycle before a read is declared lost.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  dmem_state_e     state_q, state_d;
  dmem_bus_req_t   req_q;
  logic [OFF_W-1:0] off_q;
  logic            misalign_q;
  logic            fault_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [CNT_W-1:0] cnt_q;

  logic                  accept;
  logic                  timeout_hit;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] st_data_sh;
  logic [MASK_W-1:0]     st_mask_sh;
  logic                  st_misalign;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  busy, done, req_valid, rsp_ready;

  // Stores win over loads when the LSU raises both enables.
  assign accept   = bus.i_lsu_valid && (bus.i_lsu_ram_wr_en || bus.i_lsu_ram_rd_en);
  assign lsu_addr = bus.i_lsu_ram_wr_en ? bus.i_lsu_ram_wr_addr : bus.i_lsu_ram_rd_addr;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

  dmem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_off      (lsu_addr[OFF_W-1:0]),
    .st_data     (bus.i_lsu_ram_wr_data),
    .st_mask     (bus.i_lsu_ram_wr_mask),
    .st_data_sh  (st_data_sh),
    .st_mask_sh  (st_mask_sh),
    .st_misalign (st_misalign),
    .ld_off      (off_q),
    .ld_word     (bus.i_bus_rsp_data),
    .ld_data     (ld_data)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a
    // signal unassigned and infers a latch.
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_d = (bus.i_lsu_ram_wr_en && st_misalign) ? DONE : REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (bus.i_bus_req_ready) state_d = req_q.we ? DONE : WAIT;
      end
      WAIT: begin
        rsp_ready = 1'b1;
        if (bus.i_bus_rsp_valid || timeout_hit) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, timeout counter, completion flags and load data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_q      <= '0;
      off_q      <= '0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q.we   <= bus.i_lsu_ram_wr_en;
            req_q.addr <= {lsu_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            req_q.data <= bus.i_lsu_ram_wr_en ? st_data_sh : '0;
            req_q.mask <= bus.i_lsu_ram_wr_en ? st_mask_sh : '0;
            off_q      <= lsu_addr[OFF_W-1:0];
            misalign_q <= bus.i_lsu_ram_wr_en && st_misalign;
            fault_q    <= 1'b0;
          end
        end
        REQ: begin
          if (bus.i_bus_req_ready && !req_q.we) cnt_q <= '0;
        end
        WAIT: begin
          // A response in the limit cycle takes precedence over the timeout.
          if (bus.i_bus_rsp_valid) begin
            rd_data_q <= ld_data;
          end else begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (timeout_hit) begin
              fault_q   <= 1'b1;
              rd_data_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_dmem_busy        = busy;
  assign bus.o_dmem_done        = done;
  assign bus.o_dmem_misalign    = done && misalign_q;
  assign bus.o_dmem_fault       = done && fault_q;
  assign bus.o_dmem_ram_rd_data = rd_data_q;
  assign bus.o_bus_req_valid    = req_valid;
  assign bus.o_bus_req_we       = req_q.we;
  assign bus.o_bus_req_addr     = req_q.addr;
  assign bus.o_bus_req_data     = req_q.data;
  assign bus.o_bus_req_mask     = req_q.mask;
  assign bus.o_bus_rsp_ready    = rsp_ready;

endmodule

// File: tb/tb_dmem_ctl.sv
// Self-checking bench for dmem_ctl: hand-derived vector table, reset/idle corner
// sequences, then randomized transactions against a transaction-level model.
module tb_dmem_ctl;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int T  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_ctl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  dmem_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.master)
  );

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] wr_addr;
    logic [31:0] rd_addr;
    logic [63:0] data;
    logic [7:0]  mask;
    int          rdy_dly;   // REQ cycles before ready is given
    int          rsp_dly;   // WAIT cycle index carrying the response, <0 = never
    logic [63:0] word;
  } vec_t;

  typedef struct {
    int          done_cyc;
    bit          misalign;
    bit          fault;
    bit          bus_seen;
    bit          we;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [63:0] rd_data;
    int          wait_cyc;
  } exp_t;

  typedef struct {
    exp_t e;
    bit   stable;
    int   done_count;
  } obs_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } row_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: what the LSU and the bus should see for one request.
  function automatic exp_t predict(input vec_t v, input logic [63:0] prev_rd);
    exp_t        e;
    logic [31:0] a;
    int          off;
    logic [15:0] wide;
    bit          lost;
    e = '{default: 0};
    a = v.wr ? v.wr_addr : v.rd_addr;
    off = int'(a % 32'd8);
    wide = 16'(v.mask) << off;
    e.we = v.wr;
    e.addr = a & ~32'h7;
    e.mask = wide[7:0];
    e.data = v.wr ? (v.data << (8 * off)) : 64'd0;
    e.misalign = v.wr && (wide > 16'h00FF);
    e.bus_seen = !e.misalign;
    e.rd_data = prev_rd;
    if (e.misalign) begin
      e.done_cyc = 1;
    end else if (v.wr) begin
      e.done_cyc = 2 + v.rdy_dly;
    end else begin
      lost = (v.rsp_dly < 0) || (v.rsp_dly >= T);
      e.fault = lost;
      e.wait_cyc = lost ? T : v.rsp_dly + 1;
      e.done_cyc = 2 + v.rdy_dly + e.wait_cyc;
      e.rd_data = lost ? 64'd0 : (v.word >> (8 * off));
    end
    return e;
  endfunction

  // Presents one request, plays the memory side, and records what the DUT did.
  task automatic run_txn(input vec_t v, output obs_t o);
    int vcnt = 0;
    int wcnt = 0;
    o = '{default: 0};
    o.stable = 1'b1;
    @(negedge clk);
    bus_if.i_lsu_valid       = 1'b1;
    bus_if.i_lsu_ram_wr_en   = v.wr;
    bus_if.i_lsu_ram_rd_en   = v.rd;
    bus_if.i_lsu_ram_wr_addr = v.wr_addr;
    bus_if.i_lsu_ram_rd_addr = v.rd_addr;
    bus_if.i_lsu_ram_wr_data = v.data;
    bus_if.i_lsu_ram_wr_mask = v.mask;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus_if.i_bus_req_ready = 1'b0;
      bus_if.i_bus_rsp_valid = 1'b0;
      bus_if.i_bus_rsp_data  = {$urandom, $urandom};
      if (bus_if.o_dmem_done) begin
        o.done_count++;
        if (o.done_count == 1) begin
          o.e.done_cyc = k;
          o.e.misalign = bus_if.o_dmem_misalign;
          o.e.fault    = bus_if.o_dmem_fault;
        end
        bus_if.i_lsu_valid = 1'b0;
      end
      if (bus_if.o_bus_req_valid) begin
        if (!o.e.bus_seen) begin
          o.e.bus_seen = 1'b1;
          o.e.we   = bus_if.o_bus_req_we;
          o.e.addr = bus_if.o_bus_req_addr;
          o.e.data = bus_if.o_bus_req_data;
          o.e.mask = bus_if.o_bus_req_mask;
        end else if (o.e.we !== bus_if.o_bus_req_we || o.e.addr !== bus_if.o_bus_req_addr ||
                     o.e.data !== bus_if.o_bus_req_data || o.e.mask !== bus_if.o_bus_req_mask) begin
          o.stable = 1'b0;
        end
        bus_if.i_bus_req_ready = (vcnt >= v.rdy_dly);
        vcnt++;
      end
      if (bus_if.o_bus_rsp_ready) begin
        if (v.rsp_dly >= 0 && wcnt == v.rsp_dly) begin
          bus_if.i_bus_rsp_valid = 1'b1;
          bus_if.i_bus_rsp_data  = v.word;
        end
        wcnt++;
      end
      if (o.done_count > 0 && k >= o.e.done_cyc + 2) break;
    end
    o.e.rd_data  = bus_if.o_dmem_ram_rd_data;
    o.e.wait_cyc = wcnt;
    bus_if.i_lsu_valid = 1'b0;
  endtask

  task automatic compare(input string tag, input obs_t o, input exp_t e);
    check({tag, ".done_cyc"},  64'(o.e.done_cyc), 64'(e.done_cyc));
    check({tag, ".done_once"}, 64'(o.done_count), 64'd1);
    check({tag, ".misalign"},  64'(o.e.misalign), 64'(e.misalign));
    check({tag, ".fault"},     64'(o.e.fault), 64'(e.fault));
    check({tag, ".rd_data"},   o.e.rd_data, e.rd_data);
    check({tag, ".bus_seen"},  64'(o.e.bus_seen), 64'(e.bus_seen));
    check({tag, ".wait_cyc"},  64'(o.e.wait_cyc), 64'(e.wait_cyc));
    check({tag, ".stable"},    64'(o.stable), 64'd1);
    if (e.bus_seen) begin
      check({tag, ".bus_we"},   64'(o.e.we), 64'(e.we));
      check({tag, ".bus_addr"}, 64'(o.e.addr), 64'(e.addr));
      if (e.we) begin
        check({tag, ".bus_mask"}, 64'(o.e.mask), 64'(e.mask));
        check({tag, ".bus_data"}, o.e.data, e.data);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".busy"},      64'(bus_if.o_dmem_busy), 64'd0);
    check({tag, ".done"},      64'(bus_if.o_dmem_done), 64'd0);
    check({tag, ".misalign"},  64'(bus_if.o_dmem_misalign), 64'd0);
    check({tag, ".fault"},     64'(bus_if.o_dmem_fault), 64'd0);
    check({tag, ".rd_data"},   bus_if.o_dmem_ram_rd_data, 64'd0);
    check({tag, ".req_valid"}, 64'(bus_if.o_bus_req_valid), 64'd0);
    check({tag, ".req_we"},    64'(bus_if.o_bus_req_we), 64'd0);
    check({tag, ".req_addr"},  64'(bus_if.o_bus_req_addr), 64'd0);
    check({tag, ".req_data"},  bus_if.o_bus_req_data, 64'd0);
    check({tag, ".req_mask"},  64'(bus_if.o_bus_req_mask), 64'd0);
    check({tag, ".rsp_ready"}, 64'(bus_if.o_bus_rsp_ready), 64'd0);
  endtask

  initial begin
    row_t        tbl[7];
    obs_t        o;
    vec_t        v;
    exp_t        e;
    logic [63:0] model_rd;
    int          sel;

    //          wr rd wr_addr       rd_addr       data                    mask   rdy rsp word
    tbl[0] = '{'{1, 0, 32'h1003, 32'h0, 64'hBEEF, 8'h03, 0, 0, 64'h0},
               '{2, 0, 0, 1, 1, 32'h1000, 64'h000000BEEF000000, 8'h18, 64'h0, 0}};
    tbl[1] = '{'{1, 0, 32'h1007, 32'h0, 64'h1234, 8'h03, 0, 0, 64'h0},
               '{1, 1, 0, 0, 1, 32'h0, 64'h0, 8'h0, 64'h0, 0}};
    tbl[2] = '{'{0, 1, 32'h0, 32'h3000, 64'h0, 8'h00, 0, -1, 64'h0},
               '{6, 0, 1, 1, 0, 32'h3000, 64'h0, 8'h0, 64'h0, 4}};
    tbl[3] = '{'{1, 0, 32'h0010, 32'h0, 64'hDEADBEEF, 8'h0F, 2, 0, 64'h0},
               '{4, 0, 0, 1, 1, 32'h0010, 64'hDEADBEEF, 8'h0F, 64'h0, 0}};
    tbl[4] = '{'{0, 1, 32'h0, 32'h2004, 64'h0, 8'h00, 3, 2, 64'h8877665544332211},
               '{8, 0, 0, 1, 0, 32'h2000, 64'h0, 8'h0, 64'h0000000088776655, 3}};
    tbl[5] = '{'{1, 1, 32'h4000, 32'h5000, 64'h1122334455667788, 8'hFF, 1, 0, 64'h0},
               '{3, 0, 0, 1, 1, 32'h4000, 64'h1122334455667788, 8'hFF, 64'h0000000088776655, 0}};
    tbl[6] = '{'{0, 1, 32'h0, 32'h3001, 64'h0, 8'h00, 0, 3, 64'h0123456789ABCDEF},
               '{6, 0, 0, 1, 0, 32'h3000, 64'h0, 8'h0, 64'h000123456789ABCD, 4}};

    bus_if.i_lsu_valid       = 1'b0;
    bus_if.i_lsu_ram_rd_en   = 1'b0;
    bus_if.i_lsu_ram_rd_addr = '0;
    bus_if.i_lsu_ram_wr_en   = 1'b0;
    bus_if.i_lsu_ram_wr_addr = '0;
    bus_if.i_lsu_ram_wr_data = '0;
    bus_if.i_lsu_ram_wr_mask = '0;
    bus_if.i_bus_req_ready   = 1'b0;
    bus_if.i_bus_rsp_valid   = 1'b0;
    bus_if.i_bus_rsp_data    = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].v, o);
      compare($sformatf("vec%0d", i), o, tbl[i].e);
    end

    // Valid with neither enable must leave the controller idle.
    @(negedge clk);
    bus_if.i_lsu_valid     = 1'b1;
    bus_if.i_lsu_ram_wr_en = 1'b0;
    bus_if.i_lsu_ram_rd_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("noen%0d.busy", k), 64'(bus_if.o_dmem_busy), 64'd0);
      check($sformatf("noen%0d.req_valid", k), 64'(bus_if.o_bus_req_valid), 64'd0);
    end
    bus_if.i_lsu_valid = 1'b0;

    // Reset asserted mid-WAIT, then a stray response, then a normal load.
    @(negedge clk);
    bus_if.i_lsu_valid       = 1'b1;
    bus_if.i_lsu_ram_rd_en   = 1'b1;
    bus_if.i_lsu_ram_rd_addr = 32'h6000;
    @(negedge clk);
    check("rstseq.req_valid", 64'(bus_if.o_bus_req_valid), 64'd1);
    bus_if.i_bus_req_ready = 1'b1;
    @(negedge clk);
    bus_if.i_bus_req_ready = 1'b0;
    check("rstseq.rsp_ready", 64'(bus_if.o_bus_rsp_ready), 64'd1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    bus_if.i_lsu_valid     = 1'b0;
    bus_if.i_lsu_ram_rd_en = 1'b0;
    bus_if.i_bus_rsp_valid = 1'b1;
    bus_if.i_bus_rsp_data  = 64'hFFFF_EEEE_DDDD_CCCC;
    check("stray.rsp_ready", 64'(bus_if.o_bus_rsp_ready), 64'd0);
    @(negedge clk);
    bus_if.i_bus_rsp_valid = 1'b0;
    check("stray.busy", 64'(bus_if.o_dmem_busy), 64'd0);
    check("stray.rd_data", bus_if.o_dmem_ram_rd_data, 64'd0);
    model_rd = 64'd0;
    v = '{0, 1, 32'h0, 32'h7006, 64'h0, 8'h00, 0, 1, 64'hCAFEF00DDEADBEEF};
    e = predict(v, model_rd);
    run_txn(v, o);
    compare("post_rst", o, e);
    model_rd = e.rd_data;

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 4));
      v.wr      = (sel < 2) || (sel == 4);
      v.rd      = (sel >= 2);
      v.wr_addr = $urandom;
      v.rd_addr = $urandom;
      v.data    = {$urandom, $urandom};
      v.mask    = 8'($urandom);
      v.rdy_dly = int'($urandom_range(0, 3));
      v.rsp_dly = int'($urandom_range(0, 6)) - 1;
      v.word    = {$urandom, $urandom};
      e = predict(v, model_rd);
      run_txn(v, o);
      compare($sformatf("rnd%0d", i), o, e);
      model_rd = e.rd_data;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
